fetch_unit: RTL and testbench

- Instruction-fetch stage. Consumes the jump, branch and register-jump decisions that instruction decode produces, and drives the PC.
- Fetches from instruction memory over a req/ready handshake and loads the IF/ID pipeline register.
- Handles decode-stage stall and redirect. There is no delay slot: every redirect squashes the wrong-path fetch.

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_unit_next_pc_sel.sv | 34 +++
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
//==================================================================
// fetch_unit_pkg - shared types/constants for the fetch stage. rev 1.0
//==================================================================
package fetch_unit_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] NOP_WORD   = 32'h0000_0000;
  localparam logic [PC_W-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  function automatic logic [PC_W-1:0] pc_plus4(input logic [PC_W-1:0] p);
    return p + PC_W'(4);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_next_pc_sel.sv
`default_nettype none
//==================================================================
// fetch_unit_next_pc_sel - redirect priority and target mux. rev 1.0
//==================================================================
module fetch_unit_next_pc_sel
  import fetch_unit_pkg::*;
(
  input  logic            jr_sel,
  input  logic            jump,
  input  logic            branch_taken,
  input  logic            stall,
  input  logic            ifid_valid,
  input  logic [PC_W-1:0] jr_target,
  input  logic [25:0]     jump_index,
  input  logic [3:0]      pc4_hi,
  input  logic [PC_W-1:0] branch_target,
  output logic            redirect,
  output logic [PC_W-1:0] target
);

  logic [PC_W-1:0] w_raw;

  assign redirect = (jr_sel | jump | branch_taken) & ~stall & ifid_valid;

  always_comb begin
    w_raw = branch_target;
    if (jr_sel)    w_raw = jr_target;
    else if (jump) w_raw = {pc4_hi, jump_index, 2'b00};
  end

  assign target = w_raw & ALIGN_MASK;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
//==================================================================
// fetch_unit - IF stage: PC, imem req/ready fetch, IF/ID register. rev 1.0
//==================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [PC_W-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic            jump,
  input  logic            jr_sel,
  input  logic [PC_W-1:0] branch_target,
  input  logic [25:0]     jump_index,
  input  logic [PC_W-1:0] jr_target,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [PC_W-1:0] imem_rdata,
  output logic [PC_W-1:0] pc,
  output logic            ifid_valid,
  output logic [PC_W-1:0] ifid_instr,
  output logic [PC_W-1:0] ifid_pc4
);

  fetch_state_e    r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_drain_addr;
  logic            r_req;
  logic [PC_W-1:0] r_hold_instr;
  logic [PC_W-1:0] r_hold_pc4;
  logic            r_ifid_valid;
  logic [PC_W-1:0] r_ifid_instr;
  logic [PC_W-1:0] r_ifid_pc4;

  logic            w_redirect;
  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] w_pc4;

  fetch_unit_next_pc_sel u_next_pc_sel (
    .jr_sel        (jr_sel),
    .jump          (jump),
    .branch_taken  (branch_taken),
    .stall         (stall),
    .ifid_valid    (r_ifid_valid),
    .jr_target     (jr_target),
    .jump_index    (jump_index),
    .pc4_hi        (r_ifid_pc4[PC_W-1:PC_W-4]),
    .branch_target (branch_target),
    .redirect      (w_redirect),
    .target        (w_target)
  );

  assign w_pc4 = pc_plus4(r_pc);

  // While draining, the abandoned request's address must stay on the bus.
  assign imem_addr  = ((r_state == ST_DRAIN) ? r_drain_addr : r_pc) & ALIGN_MASK;
  assign imem_req   = r_req;
  assign pc         = r_pc;
  assign ifid_valid = r_ifid_valid;
  assign ifid_instr = r_ifid_instr;
  assign ifid_pc4   = r_ifid_pc4;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_REQ;
      r_pc         <= RESET_PC;
      r_req        <= 1'b0;
      r_drain_addr <= '0;
      r_hold_instr <= NOP_INSTR;
      r_hold_pc4   <= '0;
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pc4   <= '0;
    end else begin
      r_req <= 1'b1;
      case (r_state)
        ST_REQ: begin
          // r_req low only in the first cycle after reset: nothing outstanding yet.
          if (r_req) begin
            if (w_redirect) begin
              r_pc         <= w_target;
              r_ifid_valid <= 1'b0;
              r_ifid_instr <= NOP_INSTR;
              r_ifid_pc4   <= '0;
              if (!imem_ready) begin
                r_drain_addr <= r_pc & ALIGN_MASK;
                r_state      <= ST_DRAIN;
              end
            end else if (imem_ready) begin
              if (stall) begin
                r_hold_instr <= imem_rdata;
                r_hold_pc4   <= w_pc4;
                r_req        <= 1'b0;
                r_state      <= ST_HOLD;
              end else begin
                r_ifid_valid <= 1'b1;
                r_ifid_instr <= imem_rdata;
                r_ifid_pc4   <= w_pc4;
                r_pc         <= w_pc4;
              end
            end
          end
        end
        ST_HOLD: begin
          if (stall) begin
            r_req <= 1'b0;
          end else begin
            r_state <= ST_REQ;
            if (w_redirect) begin
              r_pc         <= w_target;
              r_ifid_valid <= 1'b0;
              r_ifid_instr <= NOP_INSTR;
              r_ifid_pc4   <= '0;
            end else begin
              r_ifid_valid <= 1'b1;
              r_ifid_instr <= r_hold_instr;
              r_ifid_pc4   <= r_hold_pc4;
              r_pc         <= w_pc4;
            end
          end
        end
        ST_DRAIN: begin
          if (w_redirect) r_pc <= w_target;
          if (imem_ready) r_state <= ST_REQ;
        end
        default: r_state <= ST_REQ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
//==================================================================
// tb_fetch_unit - directed and randomized self-checking bench. rev 1.0
//==================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump, jr_sel, imem_ready;
  logic [31:0] branch_target, jr_target, imem_rdata;
  logic [25:0] jump_index;
  logic        imem_req, ifid_valid;
  logic [31:0] imem_addr, pc, ifid_instr, ifid_pc4;

  int tests = 0;
  int fails = 0;

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .jump(jump), .jr_sel(jr_sel), .branch_target(branch_target),
    .jump_index(jump_index), .jr_target(jr_target), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .pc(pc), .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4)
  );

  always #5 clk = ~clk;

  // Reference model: architectural next-PC, an outstanding fetch that may be
  // marked wrong-path, and a one-deep buffer for an instruction caught by stall.
  logic [31:0] m_pc, m_old, m_hi, m_hp4, m_ifi, m_ifp;
  bit          m_req, m_disc, m_held, m_ifv;

  function automatic logic [31:0] m_addr();
    return m_disc ? m_old : (m_pc & 32'hFFFF_FFFC);
  endfunction

  task automatic model_step();
    logic        redir, acc;
    logic [31:0] tgt, a, data;
    if (reset) begin
      m_pc = 32'h0; m_req = 0; m_disc = 0; m_held = 0;
      m_ifv = 0; m_ifi = 32'h0; m_ifp = 32'h0; m_old = 32'h0;
    end else begin
      redir = (jr_sel | jump | branch_taken) && !stall && m_ifv;
      tgt   = jr_sel ? jr_target : (jump ? {m_ifp[31:28], jump_index, 2'b00} : branch_target);
      tgt   = tgt & 32'hFFFF_FFFC;
      acc   = m_req && imem_ready;
      a     = m_addr();
      data  = 32'h1000 + a;
      if (m_held) begin
        if (!stall) begin
          m_held = 0; m_req = 1;
          if (redir) begin m_pc = tgt; m_ifv = 0; m_ifi = 0; m_ifp = 0; end
          else begin m_ifv = 1; m_ifi = m_hi; m_ifp = m_hp4; m_pc = m_pc + 4; end
        end
      end else if (!m_req) begin
        m_req = 1;
      end else if (m_disc) begin
        if (redir) m_pc = tgt;
        if (acc) m_disc = 0;
      end else if (redir) begin
        if (!acc) begin m_old = a; m_disc = 1; end
        m_pc = tgt; m_ifv = 0; m_ifi = 0; m_ifp = 0;
      end else if (acc) begin
        if (stall) begin m_held = 1; m_req = 0; m_hi = data; m_hp4 = m_pc + 4; end
        else begin m_ifv = 1; m_ifi = data; m_ifp = m_pc + 4; m_pc = m_pc + 4; end
      end
    end
  endtask

  // Memory returns 32'h1000 + address for whatever address is presented.
  task automatic tick();
    imem_rdata = 32'h1000 + imem_addr;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; branch_taken = 0; jump = 0; jr_sel = 0; imem_ready = 0;
    branch_target = 0; jr_target = 0; jump_index = 0;
  endtask

  task automatic restart();
    clear_inputs();
    reset = 1; tick();
    reset = 0; tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1; tick(); tick();
    tests++; if (pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", imem_req); end
    tests++; if (ifid_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", ifid_valid); end
    tests++; if (ifid_instr !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h want 0", ifid_instr); end
    tests++; if (ifid_pc4 !== 32'h0) begin fails++; $display("FAIL reset_pc4: got %h want 0", ifid_pc4); end
    reset = 0; tick();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      fails++; $display("FAIL first_req: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream();
    restart();
    imem_ready = 1;
    for (int k = 0; k < 8; k++) begin
      tick();
      tests++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h1000 + 32'(4*k)) begin
        fails++; $display("FAIL stream_instr[%0d]: got v=%b %h want v=1 %h", k, ifid_valid, ifid_instr, 32'h1000 + 32'(4*k));
      end
      tests++; if (ifid_pc4 !== 32'(4*k+4) || imem_addr !== 32'(4*k+4)) begin
        fails++; $display("FAIL stream_pc4[%0d]: got pc4=%h addr=%h want %h", k, ifid_pc4, imem_addr, 32'(4*k+4));
      end
    end
  endtask

  task automatic test_stall();
    restart();
    imem_ready = 1; tick(); tick();
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++; if (pc !== 32'h8 || ifid_instr !== 32'h1004 || imem_req !== 1'b0) begin
        fails++; $display("FAIL stall_hold[%0d]: got pc=%h instr=%h req=%b want pc=8 instr=1004 req=0", k, pc, ifid_instr, imem_req);
      end
    end
    stall = 0; imem_ready = 0; tick();
    tests++; if (ifid_instr !== 32'h1008 || ifid_pc4 !== 32'hC) begin
      fails++; $display("FAIL stall_release: got instr=%h pc4=%h want 1008 c", ifid_instr, ifid_pc4);
    end
    tests++; if (pc !== 32'hC || imem_req !== 1'b1 || imem_addr !== 32'hC) begin
      fails++; $display("FAIL stall_next_req: got pc=%h req=%b addr=%h want c 1 c", pc, imem_req, imem_addr);
    end
  endtask

  task automatic test_jump();
    restart();
    imem_ready = 1; tick();
    branch_taken = 1; branch_target = 32'h1000_000C; tick();
    branch_taken = 0; tick();
    tests++; if (ifid_pc4 !== 32'h1000_0010 || ifid_instr !== 32'h1000_100C) begin
      fails++; $display("FAIL jump_setup: got pc4=%h instr=%h want 10000010 1000100c", ifid_pc4, ifid_instr);
    end
    jump = 1; jump_index = 26'h0000040; imem_ready = 0; tick();
    tests++; if (pc !== 32'h1000_0100 || ifid_valid !== 1'b0) begin
      fails++; $display("FAIL jump_redirect: got pc=%h v=%b want 10000100 0", pc, ifid_valid);
    end
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h1000_0010) begin
      fails++; $display("FAIL jump_drain_addr: got req=%b addr=%h want 1 10000010", imem_req, imem_addr);
    end
    jump = 0; imem_ready = 1; tick();
    tests++; if (imem_addr !== 32'h1000_0100 || ifid_valid !== 1'b0) begin
      fails++; $display("FAIL jump_fetch_addr: got addr=%h v=%b want 10000100 0", imem_addr, ifid_valid);
    end
    tick();
    tests++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h1000_1100) begin
      fails++; $display("FAIL jump_target_instr: got v=%b %h want 1 10001100", ifid_valid, ifid_instr);
    end
  endtask

  task automatic test_drain_latency();
    restart();
    imem_ready = 1; tick();
    imem_ready = 0; branch_taken = 1; branch_target = 32'h200; tick();
    tests++; if (imem_addr !== 32'h4 || ifid_valid !== 1'b0 || pc !== 32'h200) begin
      fails++; $display("FAIL drain_start: got addr=%h v=%b pc=%h want 4 0 200", imem_addr, ifid_valid, pc);
    end
    branch_taken = 0; tick();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      fails++; $display("FAIL drain_stable: got req=%b addr=%h want 1 4", imem_req, imem_addr);
    end
    imem_ready = 1; tick();
    tests++; if (imem_addr !== 32'h200 || ifid_valid !== 1'b0) begin
      fails++; $display("FAIL drain_discard: got addr=%h v=%b want 200 0", imem_addr, ifid_valid);
    end
    tick();
    tests++; if (ifid_instr !== 32'h1200 || ifid_pc4 !== 32'h204) begin
      fails++; $display("FAIL drain_target: got instr=%h pc4=%h want 1200 204", ifid_instr, ifid_pc4);
    end
  endtask

  task automatic test_priority_and_reset_in_drain();
    restart();
    imem_ready = 1; tick();
    imem_ready = 0; stall = 1; jr_sel = 1; jump = 1; branch_taken = 1;
    jr_target = 32'h40; jump_index = 26'h5; branch_target = 32'h80; tick();
    tests++; if (pc !== 32'h4 || ifid_valid !== 1'b1) begin
      fails++; $display("FAIL prio_stalled: got pc=%h v=%b want 4 1", pc, ifid_valid);
    end
    stall = 0; tick();
    tests++; if (pc !== 32'h40 || ifid_valid !== 1'b0) begin
      fails++; $display("FAIL prio_jr: got pc=%h v=%b want 40 0", pc, ifid_valid);
    end
    clear_inputs();
    reset = 1; tick();
    tests++; if (pc !== 32'h0 || ifid_valid !== 1'b0 || imem_req !== 1'b0) begin
      fails++; $display("FAIL drain_reset: got pc=%h v=%b req=%b want 0 0 0", pc, ifid_valid, imem_req);
    end
    reset = 0; tick();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      fails++; $display("FAIL drain_reset_req: got req=%b addr=%h want 1 0", imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap();
    restart();
    imem_ready = 1; tick();
    branch_taken = 1; branch_target = 32'hFFFF_FFFE; tick();
    tests++; if (pc !== 32'hFFFF_FFFC || imem_addr !== 32'hFFFF_FFFC) begin
      fails++; $display("FAIL wrap_align: got pc=%h addr=%h want fffffffc", pc, imem_addr);
    end
    branch_taken = 0; tick();
    tests++; if (pc !== 32'h0 || ifid_pc4 !== 32'h0 || ifid_instr !== 32'h0000_0FFC || imem_addr !== 32'h0) begin
      fails++; $display("FAIL wrap_pc: got pc=%h pc4=%h instr=%h addr=%h want 0 0 ffc 0", pc, ifid_pc4, ifid_instr, imem_addr);
    end
  endtask

  task automatic test_random();
    restart();
    for (int n = 0; n < 600; n++) begin
      reset         = ($urandom_range(0, 79) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      imem_ready    = ($urandom_range(0, 2) != 0);
      jr_sel        = ($urandom_range(0, 11) == 0);
      jump          = ($urandom_range(0, 9) == 0);
      branch_taken  = ($urandom_range(0, 7) == 0);
      jr_target     = $urandom;
      branch_target = $urandom;
      jump_index    = 26'($urandom);
      tick();
      tests++; if (pc !== m_pc) begin fails++; $display("FAIL rand_pc[%0d]: got %h want %h", n, pc, m_pc); end
      tests++; if (imem_req !== m_req) begin fails++; $display("FAIL rand_req[%0d]: got %b want %b", n, imem_req, m_req); end
      if (m_req) begin
        tests++; if (imem_addr !== m_addr()) begin fails++; $display("FAIL rand_addr[%0d]: got %h want %h", n, imem_addr, m_addr()); end
      end
      tests++; if (ifid_valid !== m_ifv || ifid_instr !== m_ifi || ifid_pc4 !== m_ifp) begin
        fails++; $display("FAIL rand_ifid[%0d]: got %b %h %h want %b %h %h", n, ifid_valid, ifid_instr, ifid_pc4, m_ifv, m_ifi, m_ifp);
      end
    end
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    imem_rdata = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_jump();
    test_drain_latency();
    test_priority_and_reset_in_drain();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
